muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU over several cycles, in parallel with the single-cycle ALU. The ALU decoder sends these ops here instead of to the ALU. The pipeline stalls on `busy` and reads results through `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency: divide WIDTH+1 cycles; multiply WIDTH+1 with MULDIV_SEQ_MULT_EN defined, else 1.
// Backpressure: no queueing; start is ignored while busy and the pipeline stalls on busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_SEQ_MULT_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic               neg_r;
  logic               dz_q;

  logic               is_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               launch, div_zero, last;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign is_signed = ~op[0];
  assign sign_a    = is_signed & a[WIDTH-1];
  assign sign_b    = is_signed & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;
  assign div_zero  = (b == '0);
  assign last      = (cnt == CW'(WIDTH-1));

`ifdef MULDIV_SEQ_MULT_EN
  assign busy = (state_q == MUL) || (state_q == DIV);
`else
  assign busy = (state_q == DIV);
`endif
  assign done        = (state_q == DONE);
  assign div_by_zero = done & dz_q;
  assign launch      = start & ~flush & ~busy;

`ifdef MULDIV_SEQ_MULT_EN
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, mul_prod;
`else
  logic [2*WIDTH-1:0] mul_full, mul_res;
  assign mul_full = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign mul_res  = (sign_a ^ sign_b) ? -mul_full : mul_full;
`endif

  // One iteration of the active op, plus the sign-corrected result of that iteration.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (div_diff[WIDTH])
      step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    res_lo = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    res_hi = neg_r ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SEQ_MULT_EN
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_step = {mul_sum, acc[WIDTH-1:1]};
    mul_prod = neg_q ? -mul_step : mul_step;
    if (state_q == MUL) begin
      step_acc = mul_step;
      res_hi   = mul_prod[2*WIDTH-1:WIDTH];
      res_lo   = mul_prod[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (launch) begin
          if (op[1]) state_d = div_zero ? DONE : DIV;
`ifdef MULDIV_SEQ_MULT_EN
          else       state_d = MUL;
`else
          else       state_d = DONE;
`endif
        end
      end
`ifdef MULDIV_SEQ_MULT_EN
      MUL: if (last) state_d = DONE;
`endif
      DIV: if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Result writes come after MTHI/MTLO so a same-edge result wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      opb   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      dz_q <= launch & op[1] & div_zero;
      if (!flush && !busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (launch) begin
        cnt   <= '0;
        neg_q <= sign_a ^ sign_b;
        neg_r <= sign_a;
        if (op[1]) begin
          acc <= {{WIDTH{1'b0}}, mag_a};
          opb <= mag_b;
        end else begin
`ifdef MULDIV_SEQ_MULT_EN
          acc <= {{WIDTH{1'b0}}, mag_b};
          opb <= mag_a;
`else
          hi  <= mul_res[2*WIDTH-1:WIDTH];
          lo  <= mul_res[WIDTH-1:0];
`endif
        end
      end else if (busy && !flush) begin
        cnt <= cnt + CW'(1);
        acc <= step_acc;
        if (last) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

`ifdef MULDIV_SEQ_MULT_EN
  localparam bit MUL_SEQ = 1'b1;
`else
  localparam bit MUL_SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result of one op; divide by zero leaves HI/LO as they are.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    longint          p, q, r;
    longint unsigned pu, qu, ru;
    eh = m_hi; el = m_lo; ez = 1'b0;
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin pu = ux * uy; eh = pu[63:32]; el = pu[31:0]; end
      2'b10: if (y == 0) ez = 1'b1;
             else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
      default: if (y == 0) ez = 1'b1;
               else begin qu = ux / uy; ru = ux % uy; el = qu[31:0]; eh = ru[31:0]; end
    endcase
  endfunction

  // Called and returning at a negedge; leaves off in the done cycle so a following call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit wr, input bit poke);
    logic [31:0] eh, el;
    logic        ez, b1;
    int          lat, n, bc;
    if (wr) m_lo = 32'h5555_AAAA;
    model(o, x, y, eh, el, ez);
    if (o[1]) lat = (y == 0) ? 1 : 33;
    else      lat = MUL_SEQ ? 33 : 1;
    op = o; a = x; b = y; start = 1'b1; lo_we = wr; wdata = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    if (wr) chk("wr_with_start", 64'(lo), 64'(32'h5555_AAAA));
    n = 1; bc = 0; b1 = 1'b0;
    forever begin
      if (n == 1) b1 = busy;
      if (done) break;
      bc += int'(busy);
      if (poke && lat > 5 && n == 3) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (n == 4) begin
        hi_we = 1'b0; lo_we = 1'b0;
        chk("we_while_busy", {hi, lo}, {m_hi, m_lo});
      end
      if (n > 80) begin chk("done_timeout", 64'(0), 64'(1)); break; end
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("busy_cycles", 64'(bc), 64'(lat - 1));
    chk("busy_next_cycle", 64'(b1), 64'(lat > 1));
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("div_by_zero", 64'(div_by_zero), 64'(ez));
    m_hi = eh; m_lo = el;
  endtask

  task automatic mt(input bit h, input logic [31:0] d);
    hi_we = h; lo_we = ~h; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) m_hi = d; else m_lo = d;
    chk(h ? "mthi" : "mtlo", 64'(h ? hi : lo), 64'(d));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int          ndone;

    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_by_zero), 64'(0));
    resetn = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    chk("mult_lo", 64'(lo), 64'(32'hFFFF_FFF1));
    @(negedge clk);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    chk("div_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    chk("div_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    @(negedge clk);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo", 64'(lo), 64'(32'h8000_0000));
    chk("ovf_hi", 64'(hi), 64'(0));

    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("dz_hi", 64'(hi), 64'(32'h11));
    chk("dz_lo", 64'(lo), 64'(32'h22));
    @(negedge clk);
    chk("dz_done_one_cycle", 64'(done), 64'(0));

    // Flush in cycle k+10 of a DIVU.
    op = 2'b11; a = 32'hFFFF_FFFF; b = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    ndone = 0;
    repeat (40) begin
      ndone += int'(done);
      @(negedge clk);
    end
    chk("flush_no_done", 64'(ndone), 64'(0));
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    chk("rerun_lo", 64'(lo), 64'(32'h0FFF_FFFF));
    chk("rerun_hi", 64'(hi), 64'(32'hF));
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("multu_hi", 64'(hi), 64'(32'hFFFF_FFFE));
    chk("multu_lo", 64'(lo), 64'(32'h0000_0001));
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
    chk("b2b_lo", 64'(lo), 64'(14));
    chk("b2b_hi", 64'(hi), 64'(2));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 6))
        0: ry = 32'd0;
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) mt(1'b1, $urandom);
      run_op(ro, rx, ry, 1'b0, (i % 4) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a divide.
    op = 2'b10; a = 32'h1234_5678; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midop_rst_hi", 64'(hi), 64'(0));
    chk("midop_rst_lo", 64'(lo), 64'(0));
    chk("midop_rst_busy", 64'(busy), 64'(0));
    chk("midop_rst_done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
